rt_cmd_sched: RTL and testbench

Real-time command scheduler in the 48 MHz synchronizer domain. Expands one burst descriptor (base start time, period, count) into a series of command writes into the real-time command register, driving its write strobe and TIME_START field. Bounds the number of commands pending in the register by tracking consumption requests from the synchronizer. Skips commands whose start time is already too close to the current system time.

---
 rtl/rt_cmd_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_rt_cmd_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_cmd_sched.sv
// rt_cmd_sched - real-time command scheduler (48 MHz synchronizer domain).
//
// Expands one burst descriptor (BASE_TIME, PERIOD, COUNT) into a series of
// writes into the real-time command register. Each write holds TIME_START
// and raises SPI_WR for WR_LEN cycles, followed by GAP idle cycles. At most
// MAX_OUT commands may be written but not yet consumed (REQ_COMM).
//
// Optional feature macro: RT_SCHED_LATE_SKIP_EN
//   defined   - commands starting less than GUARD ticks after TIME are
//               skipped and counted in LATE_CNT
//   undefined - every command is written, LATE_CNT reads 0, GUARD unused
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   START               pulse: latch descriptor and start a burst (IDLE only)
//   ABORT               terminate burst, no DONE
//   BASE_TIME/PERIOD/COUNT  burst descriptor
//   TIME                current system time
//   SYS_TIME_UPDATE_OK  time reload; kills a running burst and sets ERR
//   REQ_COMM            pulse: one command consumed
//   TIME_START, SPI_WR  command register write data and strobe
//   BUSY, DONE, ERR     status
//   WR_CNT, LATE_CNT    per-burst written / skipped counts
//   OUTSTANDING         written, not yet consumed commands
module rt_cmd_sched #(
    parameter int unsigned WR_LEN  = 5,
    parameter int unsigned GAP     = 8,
    parameter int unsigned MAX_OUT = 16,
    parameter int unsigned GUARD   = 48
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        ABORT,
    input  logic [63:0] BASE_TIME,
    input  logic [31:0] PERIOD,
    input  logic [15:0] COUNT,
    input  logic [63:0] TIME,
    input  logic        SYS_TIME_UPDATE_OK,
    input  logic        REQ_COMM,
    output logic [63:0] TIME_START,
    output logic        SPI_WR,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] WR_CNT,
    output logic [15:0] LATE_CNT,
    output logic [7:0]  OUTSTANDING
);
    typedef enum logic [2:0] {StIdle, StCheck, StWrite, StGap, StWaitSlot} state_e;

    state_e      state_q, state_d;
    logic [15:0] phase_q, phase_d;
    logic [63:0] cur_time_q, cur_time_d;
    logic [31:0] period_q, period_d;
    logic [15:0] remaining_q, remaining_d;
    logic [63:0] time_start_q, time_start_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [7:0]  outstanding_q, outstanding_d;
    logic        wr_commit;
    logic        is_late;
    logic        slots_full;
    logic        wr_last;
    logic        gap_last;

    assign wr_last    = (phase_q == 16'(WR_LEN - 1));
    assign gap_last   = (phase_q == 16'(GAP - 1));
    assign slots_full = (outstanding_q >= 8'(MAX_OUT));

`ifdef RT_SCHED_LATE_SKIP_EN
    logic [15:0] late_cnt_q, late_cnt_d;
    // Sum wraps mod 2^64 on purpose.
    assign is_late  = (cur_time_q < (TIME + 64'(GUARD)));
    assign LATE_CNT = late_cnt_q;
`else
    logic unused_late;
    assign unused_late = ^{TIME, 32'(GUARD)};
    assign is_late     = 1'b0;
    assign LATE_CNT    = 16'd0;
`endif

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cur_time_d   = cur_time_q;
        period_d     = period_q;
        remaining_d  = remaining_q;
        time_start_d = time_start_q;
        done_d       = 1'b0;
        err_d        = err_q;
        wr_cnt_d     = wr_cnt_q;
        wr_commit    = 1'b0;
`ifdef RT_SCHED_LATE_SKIP_EN
        late_cnt_d   = late_cnt_q;
`endif
        if (ABORT) begin
            state_d = StIdle;
            phase_d = 16'd0;
        end else if (SYS_TIME_UPDATE_OK && state_q != StIdle) begin
            state_d = StIdle;
            phase_d = 16'd0;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        cur_time_d  = BASE_TIME;
                        period_d    = PERIOD;
                        remaining_d = COUNT;
                        wr_cnt_d    = 16'd0;
                        err_d       = 1'b0;
`ifdef RT_SCHED_LATE_SKIP_EN
                        late_cnt_d  = 16'd0;
`endif
                        if (COUNT == 16'd0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (remaining_q == 16'd0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (is_late) begin
                        cur_time_d  = cur_time_q + 64'(period_q);
                        remaining_d = remaining_q - 16'd1;
`ifdef RT_SCHED_LATE_SKIP_EN
                        late_cnt_d  = late_cnt_q + 16'd1;
`endif
                    end else if (slots_full) begin
                        state_d = StWaitSlot;
                    end else begin
                        time_start_d = cur_time_q;
                        phase_d      = 16'd0;
                        state_d      = StWrite;
                    end
                end
                StWrite: begin
                    if (wr_last) begin
                        wr_commit   = 1'b1;
                        wr_cnt_d    = wr_cnt_q + 16'd1;
                        cur_time_d  = cur_time_q + 64'(period_q);
                        remaining_d = remaining_q - 16'd1;
                        phase_d     = 16'd0;
                        state_d     = StGap;
                    end else begin
                        phase_d = phase_q + 16'd1;
                    end
                end
                StGap: begin
                    if (gap_last) begin
                        phase_d = 16'd0;
                        state_d = StCheck;
                    end else begin
                        phase_d = phase_q + 16'd1;
                    end
                end
                StWaitSlot: begin
                    // A consumption this cycle frees a slot in time for CHECK.
                    if (!slots_full || REQ_COMM) begin
                        state_d = StCheck;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Simultaneous write and consumption cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (wr_commit && !REQ_COMM) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (!wr_commit && REQ_COMM && outstanding_q != 8'd0) begin
            outstanding_d = outstanding_q - 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= StIdle;
            phase_q       <= 16'd0;
            cur_time_q    <= 64'd0;
            period_q      <= 32'd0;
            remaining_q   <= 16'd0;
            time_start_q  <= 64'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            wr_cnt_q      <= 16'd0;
            outstanding_q <= 8'd0;
`ifdef RT_SCHED_LATE_SKIP_EN
            late_cnt_q    <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cur_time_q    <= cur_time_d;
            period_q      <= period_d;
            remaining_q   <= remaining_d;
            time_start_q  <= time_start_d;
            done_q        <= done_d;
            err_q         <= err_d;
            wr_cnt_q      <= wr_cnt_d;
            outstanding_q <= outstanding_d;
`ifdef RT_SCHED_LATE_SKIP_EN
            late_cnt_q    <= late_cnt_d;
`endif
        end
    end

    assign TIME_START  = time_start_q;
    assign SPI_WR      = (state_q == StWrite);
    assign BUSY        = (state_q != StIdle);
    assign DONE        = done_q;
    assign ERR         = err_q;
    assign WR_CNT      = wr_cnt_q;
    assign OUTSTANDING = outstanding_q;

endmodule

// File: tb/tb_rt_cmd_sched.sv
// Bench for rt_cmd_sched: descriptor table, hand sequences for stall, abort,
// time reload and reset, plus randomized bursts against a burst-level model.
module tb_rt_cmd_sched;
    localparam int unsigned WR_LEN  = 5;
    localparam int unsigned GAP     = 8;
    localparam int unsigned MAX_OUT = 16;
    localparam int unsigned GUARD   = 48;
    localparam int          PITCH   = WR_LEN + GAP + 1;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic        SYS_TIME_UPDATE_OK = 1'b0;
    logic        REQ_COMM = 1'b0;
    logic [63:0] BASE_TIME = '0;
    logic [31:0] PERIOD = '0;
    logic [15:0] COUNT = '0;
    logic [63:0] TIME = '0;
    logic [63:0] TIME_START;
    logic        SPI_WR, BUSY, DONE, ERR;
    logic [15:0] WR_CNT, LATE_CNT;
    logic [7:0]  OUTSTANDING;

    rt_cmd_sched #(.WR_LEN(WR_LEN), .GAP(GAP), .MAX_OUT(MAX_OUT), .GUARD(GUARD)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .BASE_TIME(BASE_TIME), .PERIOD(PERIOD), .COUNT(COUNT), .TIME(TIME),
        .SYS_TIME_UPDATE_OK(SYS_TIME_UPDATE_OK), .REQ_COMM(REQ_COMM),
        .TIME_START(TIME_START), .SPI_WR(SPI_WR), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .WR_CNT(WR_CNT), .LATE_CNT(LATE_CNT), .OUTSTANDING(OUTSTANDING)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- strobe monitor ----------------
    logic [63:0] exp_q[$];
    bit  allow_short = 0;
    bit  chk_pitch = 0;
    bit  seen_rise = 0;
    int  last_rise = 0;
    int  width = 0;
    int  strobes_done = 0;
    logic prev_wr = 1'b0;

    always @(negedge CLK) begin
        if (SPI_WR && !prev_wr) begin
            chk("strobe_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("time_start", TIME_START, exp_q.pop_front());
            if (chk_pitch && seen_rise) chk("pitch", 64'(cyc - last_rise), 64'(PITCH));
            seen_rise = 1;
            last_rise = cyc;
            width = 0;
        end
        if (SPI_WR) width++;
        if (!SPI_WR && prev_wr) begin
            if (!allow_short) chk("strobe_width", 64'(width), 64'(WR_LEN));
            if (width == WR_LEN) strobes_done++;
        end
        prev_wr = SPI_WR;
    end

    // ---------------- burst-level model ----------------
    int plan_wr, plan_late;

    function automatic void plan(input logic [63:0] b, input logic [31:0] p,
                                 input logic [15:0] c, input logic [63:0] tm);
        logic [63:0] t;
        plan_wr = 0;
        plan_late = 0;
        for (int k = 0; k < int'(c); k++) begin
            t = b + 64'(k) * {32'd0, p};
`ifdef RT_SCHED_LATE_SKIP_EN
            if (t < tm + 64'(GUARD)) begin
                plan_late++;
                continue;
            end
`endif
            exp_q.push_back(t);
            plan_wr++;
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int  out_exp = 0;
    int  reqs = 0;
    int  strobes0 = 0;
    bit  rand_req = 0;

    task automatic start_burst(input logic [63:0] b, input logic [31:0] p,
                               input logic [15:0] c, input logic [63:0] tm);
        BASE_TIME = b;
        PERIOD = p;
        COUNT = c;
        TIME = tm;
        plan(b, p, c, tm);
        seen_rise = 0;
        reqs = 0;
        strobes0 = strobes_done;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (DONE) begin
                ok = 1;
            end else begin
                REQ_COMM = rand_req && (out_exp + strobes_done - strobes0 - reqs > 0)
                           && ($urandom_range(3) == 0);
                if (REQ_COMM) reqs++;
                tick();
                REQ_COMM = 1'b0;
            end
        end
    endtask

    task automatic drain();
        REQ_COMM = 1'b1;
        repeat (MAX_OUT + 4) tick();
        REQ_COMM = 1'b0;
        chk("drain_outstanding", 64'(OUTSTANDING), 64'd0);
        out_exp = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_time_start"}, TIME_START, 64'd0);
        chk({tag, "_spi_wr"}, 64'(SPI_WR), 64'd0);
        chk({tag, "_busy"}, 64'(BUSY), 64'd0);
        chk({tag, "_done"}, 64'(DONE), 64'd0);
        chk({tag, "_err"}, 64'(ERR), 64'd0);
        chk({tag, "_wr_cnt"}, 64'(WR_CNT), 64'd0);
        chk({tag, "_late_cnt"}, 64'(LATE_CNT), 64'd0);
        chk({tag, "_outstanding"}, 64'(OUTSTANDING), 64'd0);
    endtask

    typedef struct {
        logic [63:0] base;
        logic [31:0] period;
        logic [15:0] count;
        logic [63:0] tm;
        logic [15:0] exp_wr;
        logic [15:0] exp_late;
        bit          chk_ts;
        logic [63:0] exp_ts;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bit ok;
        logic [63:0] tm, b;
        logic [31:0] p;
        logic [15:0] c;

        vecs[0] = '{64'h22C0, 32'h3000, 16'd3, 64'd0, 16'd3, 16'd0, 1'b1, 64'h82C0};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FF00, 32'h200, 16'd2, 64'd0, 16'd2, 16'd0, 1'b1,
                    64'h100};
        vecs[3] = '{64'd5, 32'd1, 16'd0, 64'd0, 16'd0, 16'd0, 1'b0, 64'd0};
`ifdef RT_SCHED_LATE_SKIP_EN
        vecs[1] = '{64'h8000, 32'h800, 16'd4, 64'h9000, 16'd1, 16'd3, 1'b1, 64'h9800};
        vecs[4] = '{64'h102F, 32'd1, 16'd2, 64'h1000, 16'd1, 16'd1, 1'b1, 64'h1030};
        vecs[5] = '{64'h10, 32'd0, 16'd1, 64'hFFFF_FFFF_FFFF_FFF0, 16'd0, 16'd1, 1'b0,
                    64'd0};
`else
        vecs[1] = '{64'h8000, 32'h800, 16'd4, 64'h9000, 16'd4, 16'd0, 1'b1, 64'h9800};
        vecs[4] = '{64'h102F, 32'd1, 16'd2, 64'h1000, 16'd2, 16'd0, 1'b1, 64'h1030};
        vecs[5] = '{64'h10, 32'd0, 16'd1, 64'hFFFF_FFFF_FFFF_FFF0, 16'd1, 16'd0, 1'b1,
                    64'h10};
`endif

        // Reset values, during and after reset
        repeat (3) tick();
        chk_reset_vals("rst_hold");
        RESET = 1'b0;
        tick();
        chk_reset_vals("rst_rel");

        // Descriptor table
        foreach (vecs[i]) begin
            drain();
            chk_pitch = (i == 0);
            start_burst(vecs[i].base, vecs[i].period, vecs[i].count, vecs[i].tm);
            wait_done(400, ok);
            chk("vec_done_seen", 64'(ok), 64'd1);
            chk("vec_busy_at_done", 64'(BUSY), 64'd0);
            chk("vec_wr_cnt", 64'(WR_CNT), 64'(vecs[i].exp_wr));
            chk("vec_late_cnt", 64'(LATE_CNT), 64'(vecs[i].exp_late));
            chk("vec_outstanding", 64'(OUTSTANDING), 64'(vecs[i].exp_wr));
            if (vecs[i].chk_ts) chk("vec_last_ts", TIME_START, vecs[i].exp_ts);
            tick();
            chk("vec_done_pulse", 64'(DONE), 64'd0);
            chk("vec_queue_empty", 64'(exp_q.size()), 64'd0);
            chk_pitch = 0;
        end

        // Slot limit: fill MAX_OUT, stall, then release one slot
        drain();
        start_burst(64'h1000, 32'h100, 16'(MAX_OUT + 2), 64'd0);
        repeat (260) tick();
        chk("stall_outstanding", 64'(OUTSTANDING), 64'(MAX_OUT));
        chk("stall_wr_cnt", 64'(WR_CNT), 64'(MAX_OUT));
        chk("stall_busy", 64'(BUSY), 64'd1);
        chk("stall_spi_wr", 64'(SPI_WR), 64'd0);
        REQ_COMM = 1'b1;
        tick();
        REQ_COMM = 1'b0;
        chk("ws_exit_m1_spi", 64'(SPI_WR), 64'd0);
        tick();
        chk("ws_exit_m2_spi", 64'(SPI_WR), 64'd1);
        chk("ws_exit_outstanding", 64'(OUTSTANDING), 64'(MAX_OUT - 1));
        repeat (WR_LEN - 1) tick();
        chk("last_write_cycle", 64'(SPI_WR), 64'd1);
        REQ_COMM = 1'b1;
        tick();
        REQ_COMM = 1'b0;
        chk("inc_dec_outstanding", 64'(OUTSTANDING), 64'(MAX_OUT - 1));
        chk("inc_dec_wr_cnt", 64'(WR_CNT), 64'(MAX_OUT + 1));
        wait_done(200, ok);
        chk("stall_done_seen", 64'(ok), 64'd1);
        chk("stall_final_wr", 64'(WR_CNT), 64'(MAX_OUT + 2));
        chk("stall_final_out", 64'(OUTSTANDING), 64'(MAX_OUT));

        // ABORT in the third strobe cycle
        drain();
        allow_short = 1;
        start_burst(64'h4000, 32'h10, 16'd5, 64'd0);
        repeat (3) tick();
        chk("abort_pre_spi", 64'(SPI_WR), 64'd1);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        chk("abort_spi", 64'(SPI_WR), 64'd0);
        chk("abort_busy", 64'(BUSY), 64'd0);
        chk("abort_done", 64'(DONE), 64'd0);
        chk("abort_wr_cnt", 64'(WR_CNT), 64'd0);
        chk("abort_outstanding", 64'(OUTSTANDING), 64'd0);
        tick();
        chk("abort_done_later", 64'(DONE), 64'd0);
        allow_short = 0;
        exp_q.delete();

        // ABORT wins over START in IDLE
        START = 1'b1;
        ABORT = 1'b1;
        tick();
        START = 1'b0;
        ABORT = 1'b0;
        chk("abort_vs_start_busy", 64'(BUSY), 64'd0);

        // Time reload during GAP
        start_burst(64'h5000, 32'h10, 16'd3, 64'd0);
        repeat (WR_LEN + 2) tick();
        SYS_TIME_UPDATE_OK = 1'b1;
        tick();
        SYS_TIME_UPDATE_OK = 1'b0;
        chk("reload_busy", 64'(BUSY), 64'd0);
        chk("reload_err", 64'(ERR), 64'd1);
        chk("reload_done", 64'(DONE), 64'd0);
        chk("reload_wr_cnt", 64'(WR_CNT), 64'd1);
        chk("reload_outstanding", 64'(OUTSTANDING), 64'd1);
        exp_q.delete();
        SYS_TIME_UPDATE_OK = 1'b1;
        tick();
        SYS_TIME_UPDATE_OK = 1'b0;
        chk("reload_idle_err", 64'(ERR), 64'd1);

        // START clears ERR; start time wraps
        drain();
        start_burst(64'hFFFF_FFFF_FFFF_FF00, 32'h200, 16'd2, 64'd0);
        chk("restart_err", 64'(ERR), 64'd0);
        chk("restart_busy", 64'(BUSY), 64'd1);
        chk("restart_spi_n1", 64'(SPI_WR), 64'd0);
        tick();
        chk("restart_spi_n2", 64'(SPI_WR), 64'd1);
        chk("restart_ts_n2", TIME_START, 64'hFFFF_FFFF_FFFF_FF00);
        wait_done(200, ok);
        chk("wrap_done_seen", 64'(ok), 64'd1);
        chk("wrap_ts", TIME_START, 64'h100);

        // START while busy is ignored
        drain();
        start_burst(64'h7000, 32'h10, 16'd2, 64'd0);
        tick();
        BASE_TIME = 64'hAAAA;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done(200, ok);
        chk("busy_start_done", 64'(ok), 64'd1);
        chk("busy_start_wr_cnt", 64'(WR_CNT), 64'd2);
        chk("busy_start_ts", TIME_START, 64'h7010);

        // RESET during WRITE
        allow_short = 1;
        start_burst(64'h6000, 32'h10, 16'd3, 64'd0);
        repeat (2) tick();
        RESET = 1'b1;
        tick();
        chk_reset_vals("rst_write");
        RESET = 1'b0;
        tick();
        allow_short = 0;
        exp_q.delete();
        out_exp = 0;

        // Randomized bursts with random consumption
        rand_req = 1;
        for (int n = 0; n < 12; n++) begin
            tm = {$urandom, $urandom};
            b  = tm - 64'd128 + 64'($urandom_range(0, 256));
            p  = 32'($urandom_range(0, 64));
            c  = 16'($urandom_range(0, 12));
            start_burst(b, p, c, tm);
            wait_done(2000, ok);
            chk("rnd_done_seen", 64'(ok), 64'd1);
            chk("rnd_wr_cnt", 64'(WR_CNT), 64'(plan_wr));
            chk("rnd_late_cnt", 64'(LATE_CNT), 64'(plan_late));
            out_exp = out_exp + plan_wr - reqs;
            chk("rnd_outstanding", 64'(OUTSTANDING), 64'(out_exp));
            chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
            tick();
        end
        rand_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
